// File: rtl/cpu_pkg.sv
// Shared constants for the CPU control path: opcode map, sequencer state encoding,
// and the per-opcode length of the execute phase.
package cpu_pkg;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpShr  = 5'b00111;
    localparam logic [4:0] OpShra = 5'b01000;
    localparam logic [4:0] OpShl  = 5'b01001;
    localparam logic [4:0] OpRor  = 5'b01010;
    localparam logic [4:0] OpRol  = 5'b01011;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;
    localparam logic [4:0] OpBr   = 5'b10011;
    localparam logic [4:0] OpJr   = 5'b10100;
    localparam logic [4:0] OpJal  = 5'b10101;
    localparam logic [4:0] OpIn   = 5'b10110;
    localparam logic [4:0] OpOut  = 5'b10111;
    localparam logic [4:0] OpMfhi = 5'b11000;
    localparam logic [4:0] OpMflo = 5'b11001;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    // ALU select used for effective-address and branch-target additions
    localparam logic [4:0] AluAdd = OpAdd;

    typedef enum logic [3:0] {
        StReset,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StT7,
        StHalt
    } state_t;

    // Final execute state of each instruction; anything unlisted finishes in T3
    function automatic state_t last_state(input logic [4:0] op);
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol,
            OpAddi, OpAndi, OpOri, OpLdi:  last_state = StT5;
            OpNeg, OpNot, OpJal:           last_state = StT4;
            OpMul, OpDiv, OpBr:            last_state = StT6;
            OpLd, OpSt:                    last_state = StT7;
            default:                       last_state = StT3;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch (T0-T2), per-opcode execute (T3-T7), run/halt control.
module control_unit import cpu_pkg::*; (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        run,
    output logic [4:0]  opcode,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        HIin,
    output logic        LOin,
    output logic        Yin,
    output logic        Zin,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        OutPortin,
    output logic        CONin,
    output logic        HIout,
    output logic        LOout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        PCout,
    output logic        MDRout,
    output logic        InPortout,
    output logic        Cout
);

    state_t     r_state;
    logic [4:0] w_op;
    logic       w_exec;
    logic       w_unused_ir;

    assign w_op        = ir[31:27];
    // Register fields are decoded by select_encode in the datapath, not here
    assign w_unused_ir = ^ir[26:0];
    assign w_exec      = r_state inside {StT3, StT4, StT5, StT6, StT7};

    function automatic state_t next_exec(input state_t s);
        case (s)
            StT3:    next_exec = StT4;
            StT4:    next_exec = StT5;
            StT5:    next_exec = StT6;
            StT6:    next_exec = StT7;
            default: next_exec = StT0;
        endcase
    endfunction

    // State register: fetch steps, execute steps until the op's last state, then T0 or HALT
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= StReset;
        end else begin
            case (r_state)
                StReset: r_state <= StT0;
                StT0:    r_state <= StT1;
                StT1:    r_state <= StT2;
                StT2:    r_state <= StT3;
                StT3, StT4, StT5, StT6, StT7: begin
                    if (r_state == last_state(w_op)) begin
                        r_state <= (w_op == OpHalt || stop) ? StHalt : StT0;
                    end else begin
                        r_state <= next_exec(r_state);
                    end
                end
                StHalt:  r_state <= StHalt;
                default: r_state <= StReset;
            endcase
        end
    end

    // Output decode from (state, op, con_ff); every strobe defaults low
    always_comb begin
        run       = (r_state != StReset) && (r_state != StHalt);
        opcode    = w_exec ? w_op : 5'd0;
        Read      = 1'b0; Write    = 1'b0; IncPC   = 1'b0;
        Gra       = 1'b0; Grb      = 1'b0; Grc     = 1'b0;
        Rin       = 1'b0; Rout     = 1'b0; BAout   = 1'b0;
        HIin      = 1'b0; LOin     = 1'b0; Yin     = 1'b0;
        Zin       = 1'b0; PCin     = 1'b0; IRin    = 1'b0;
        MARin     = 1'b0; MDRin    = 1'b0; OutPortin = 1'b0;
        CONin     = 1'b0; HIout    = 1'b0; LOout   = 1'b0;
        Zhighout  = 1'b0; Zlowout  = 1'b0; PCout   = 1'b0;
        MDRout    = 1'b0; InPortout = 1'b0; Cout   = 1'b0;
        case (r_state)
            StT0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            StT1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            StT2: begin MDRout = 1'b1; IRin = 1'b1; end
            StT3: begin
                case (w_op)
                    OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol,
                    OpAddi, OpAndi, OpOri:
                        begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OpNeg, OpNot:      begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                    OpMul, OpDiv:      begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OpLd, OpLdi, OpSt: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    OpBr:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    OpJr:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OpJal:             begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                    OpIn:              begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OpOut:             begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    OpMfhi:            begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OpMflo:            begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            StT4: begin
                case (w_op)
                    OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol:
                        begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                    OpAddi, OpAndi, OpOri: begin Cout = 1'b1; Zin = 1'b1; end
                    OpNeg, OpNot:      begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OpMul, OpDiv:      begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                    OpLd, OpLdi, OpSt: begin Cout = 1'b1; Zin = 1'b1; opcode = AluAdd; end
                    OpBr:              begin PCout = 1'b1; Yin = 1'b1; end
                    OpJal:             begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default: ;
                endcase
            end
            StT5: begin
                case (w_op)
                    OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol,
                    OpAddi, OpAndi, OpOri, OpLdi:
                        begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OpMul, OpDiv:      begin Zlowout = 1'b1; LOin = 1'b1; end
                    OpLd, OpSt:        begin Zlowout = 1'b1; MARin = 1'b1; end
                    OpBr:              begin Cout = 1'b1; Zin = 1'b1; opcode = AluAdd; end
                    default: ;
                endcase
            end
            StT6: begin
                case (w_op)
                    OpMul, OpDiv:      begin Zhighout = 1'b1; HIin = 1'b1; end
                    OpLd:              begin Read = 1'b1; MDRin = 1'b1; end
                    // MDR takes the bus here, so Read stays low
                    OpSt:              begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    OpBr:              begin Zlowout = con_ff; PCin = con_ff; end
                    default: ;
                endcase
            end
            StT7: begin
                case (w_op)
                    OpLd:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OpSt:    Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-instruction expected strobe traces are queued by
// the stimulus and consumed cycle by cycle by an independent monitor.
module tb_control_unit;

    localparam logic [4:0] OpLd = 5'd0,  OpLdi = 5'd1,  OpSt = 5'd2,  OpAdd = 5'd3;
    localparam logic [4:0] OpSub = 5'd4, OpAnd = 5'd5,  OpOr = 5'd6,  OpShr = 5'd7;
    localparam logic [4:0] OpShra = 5'd8, OpShl = 5'd9, OpRor = 5'd10, OpRol = 5'd11;
    localparam logic [4:0] OpAddi = 5'd12, OpAndi = 5'd13, OpOri = 5'd14, OpMul = 5'd15;
    localparam logic [4:0] OpDiv = 5'd16, OpNeg = 5'd17, OpNot = 5'd18, OpBr = 5'd19;
    localparam logic [4:0] OpJr = 5'd20, OpJal = 5'd21, OpIn = 5'd22, OpOut = 5'd23;
    localparam logic [4:0] OpMfhi = 5'd24, OpMflo = 5'd25, OpHalt = 5'd27;

    // Strobe masks, bit positions match the act vector below
    localparam logic [26:0] MRd = 27'd1 << 0,   MWr = 27'd1 << 1,   MInc = 27'd1 << 2;
    localparam logic [26:0] MGra = 27'd1 << 3,  MGrb = 27'd1 << 4,  MGrc = 27'd1 << 5;
    localparam logic [26:0] MRin = 27'd1 << 6,  MRout = 27'd1 << 7, MBa = 27'd1 << 8;
    localparam logic [26:0] MHiIn = 27'd1 << 9, MLoIn = 27'd1 << 10, MYin = 27'd1 << 11;
    localparam logic [26:0] MZin = 27'd1 << 12, MPcIn = 27'd1 << 13, MIrIn = 27'd1 << 14;
    localparam logic [26:0] MMarIn = 27'd1 << 15, MMdrIn = 27'd1 << 16, MOpIn = 27'd1 << 17;
    localparam logic [26:0] MConIn = 27'd1 << 18, MHiOut = 27'd1 << 19, MLoOut = 27'd1 << 20;
    localparam logic [26:0] MZhi = 27'd1 << 21, MZlo = 27'd1 << 22, MPcOut = 27'd1 << 23;
    localparam logic [26:0] MMdrOut = 27'd1 << 24, MInpOut = 27'd1 << 25, MCout = 27'd1 << 26;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = 32'd0;
    logic        con_ff = 1'b0;
    logic        stop = 1'b0;
    logic        run, Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin, Yin;
    logic        Zin, PCin, IRin, MARin, MDRin, OutPortin, CONin, HIout, LOout, Zhighout;
    logic        Zlowout, PCout, MDRout, InPortout, Cout;
    logic [4:0]  opcode;

    control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop), .run(run),
        .opcode(opcode), .Read(Read), .Write(Write), .IncPC(IncPC), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .HIin(HIin), .LOin(LOin),
        .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .OutPortin(OutPortin), .CONin(CONin), .HIout(HIout), .LOout(LOout),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout),
        .InPortout(InPortout), .Cout(Cout)
    );

    always #5 clock = ~clock;

    logic [32:0] act;
    assign act = {run, opcode, Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout,
                  HIout, CONin, OutPortin, MDRin, MARin, IRin, PCin, Zin, Yin, LOin, HIin,
                  BAout, Rout, Rin, Grc, Grb, Gra, IncPC, Write, Read};

    typedef struct packed {
        logic [32:0] v;
        logic [4:0]  op;
        logic [3:0]  step;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cnt;
    int         lim;
    logic [4:0] cur_op;

    // One expected cycle of the current instruction; lim truncates for aborted runs
    function automatic void put(logic [4:0] opc, logic [26:0] st);
        exp_t e;
        e.v = {1'b1, opc, st};
        e.op = cur_op;
        e.step = cnt[3:0];
        if (cnt < lim) exp_q.push_back(e);
        cnt++;
    endfunction

    function automatic void put_idle();
        exp_t e;
        e.v = '0;
        e.op = 5'd0;
        e.step = 4'hf;
        exp_q.push_back(e);
    endfunction

    // Reference: full cycle trace of one instruction; returns 1 if it ends in HALT
    function automatic bit model(logic [4:0] op, logic con, logic stp, int limit);
        cur_op = op;
        cnt = 0;
        lim = limit;
        put(5'd0, MPcOut | MMarIn | MInc | MZin);
        put(5'd0, MZlo | MPcIn | MRd | MMdrIn);
        put(5'd0, MMdrOut | MIrIn);
        if (op inside {OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol}) begin
            put(op, MGrb | MRout | MYin); put(op, MGrc | MRout | MZin);
            put(op, MZlo | MGra | MRin);
        end else if (op inside {OpAddi, OpAndi, OpOri}) begin
            put(op, MGrb | MRout | MYin); put(op, MCout | MZin); put(op, MZlo | MGra | MRin);
        end else if (op inside {OpNeg, OpNot}) begin
            put(op, MGrb | MRout | MZin); put(op, MZlo | MGra | MRin);
        end else if (op inside {OpMul, OpDiv}) begin
            put(op, MGra | MRout | MYin); put(op, MGrb | MRout | MZin);
            put(op, MZlo | MLoIn); put(op, MZhi | MHiIn);
        end else if (op == OpLd) begin
            put(op, MGrb | MBa | MYin); put(OpAdd, MCout | MZin); put(op, MZlo | MMarIn);
            put(op, MRd | MMdrIn); put(op, MMdrOut | MGra | MRin);
        end else if (op == OpLdi) begin
            put(op, MGrb | MBa | MYin); put(OpAdd, MCout | MZin); put(op, MZlo | MGra | MRin);
        end else if (op == OpSt) begin
            put(op, MGrb | MBa | MYin); put(OpAdd, MCout | MZin); put(op, MZlo | MMarIn);
            put(op, MGra | MRout | MMdrIn); put(op, MWr);
        end else if (op == OpBr) begin
            put(op, MGra | MRout | MConIn); put(op, MPcOut | MYin); put(OpAdd, MCout | MZin);
            put(op, con ? (MZlo | MPcIn) : 27'd0);
        end else if (op == OpJr) begin
            put(op, MGra | MRout | MPcIn);
        end else if (op == OpJal) begin
            put(op, MPcOut | MGrb | MRin); put(op, MGra | MRout | MPcIn);
        end else if (op == OpIn) begin
            put(op, MInpOut | MGra | MRin);
        end else if (op == OpOut) begin
            put(op, MGra | MRout | MOpIn);
        end else if (op == OpMfhi) begin
            put(op, MHiOut | MGra | MRin);
        end else if (op == OpMflo) begin
            put(op, MLoOut | MGra | MRin);
        end else begin
            put(op, 27'd0);
        end
        return (op == OpHalt) || stp;
    endfunction

    // Monitor: every cycle the DUT presents a control word; compare against the queue head
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL ctl op=%b step=%0d actual=%h required=%h", e.op, e.step,
                         act, e.v);
            end
        end
    end

    // Entered on a cycle boundary (+1) whose expectation is not yet queued; leaves in T0
    task automatic reset_seq(input bit from_halt);
        if (from_halt) put_idle();
        clear = 1'b1;
        @(posedge clock); #1;
        put_idle();
        clear = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic run_instr(input logic [31:0] instr, input logic con, input logic stp,
                             output bit halted);
        int n;
        halted = model(instr[31:27], con, stp, 99);
        n = cnt;
        stop = stp;
        repeat (3) @(posedge clock);
        #1;
        ir = instr;
        con_ff = con;
        repeat (n - 3) @(posedge clock);
        #1;
        stop = 1'b0;
    endtask

    task automatic halt_then_reset();
        repeat (20) put_idle();
        repeat (20) @(posedge clock);
        #1;
        reset_seq(1'b1);
    endtask

    // Start a st, pull clear during its T6: no Write, one RESET cycle, then fetch again
    task automatic reset_mid_st();
        void'(model(OpSt, 1'b0, 1'b0, 7));
        repeat (3) @(posedge clock);
        #1;
        ir = 32'h10000000;
        repeat (3) @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock); #1;
        put_idle();
        clear = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        bit          h;
        logic [31:0] rnd;
        logic [31:0] instr;
        logic [4:0]  op;
        reset_seq(1'b0);
        reset_mid_st();
        run_instr(32'h18918000, 1'b0, 1'b0, h);
        run_instr(32'h00900055, 1'b0, 1'b0, h);
        run_instr(32'h98000000, 1'b1, 1'b0, h);
        run_instr(32'h98000000, 1'b0, 1'b0, h);
        run_instr(32'h78800000, 1'b0, 1'b0, h);
        run_instr(32'h18918000, 1'b0, 1'b1, h);
        if (h) halt_then_reset();
        run_instr(32'hD8000000, 1'b0, 1'b0, h);
        if (h) halt_then_reset();
        for (int i = 0; i < 80; i++) begin
            rnd = $urandom();
            op = 5'($urandom_range(0, 31));
            instr = {op, rnd[26:0]};
            run_instr(instr, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), h);
            if (h) halt_then_reset();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
